// File: rtl/apb_master_bridge.sv
// Bridges a single-outstanding req/gnt/rvalid request port onto an APB3 master,
// with PREADY wait-state handling, a bounded-wait timeout and an alignment check.
module apb_master_bridge #(
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESETn,
   input  logic                      req_i,
   input  logic [APB_ADDR_WIDTH-1:0] addr_i,
   input  logic                      we_i,
   input  logic [APB_DATA_WIDTH-1:0] wdata_i,
   output logic                      gnt_o,
   output logic                      rvalid_o,
   output logic [APB_DATA_WIDTH-1:0] rdata_o,
   output logic                      err_o,
   output logic                      PSEL,
   output logic                      PENABLE,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic                      PWRITE,
   output logic [APB_DATA_WIDTH-1:0] PWDATA,
   input  logic [APB_DATA_WIDTH-1:0] PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [APB_ADDR_WIDTH-1:0] BYTE_MASK = APB_ADDR_WIDTH'(APB_DATA_WIDTH / 8 - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic             accept;
   logic             misaligned;
   logic             timeout_hit;

   assign misaligned = |(addr_i & BYTE_MASK);
   assign accept     = req_i && gnt_o;
   // Abort on the last permitted stalled ACCESS cycle; a simultaneous PREADY still completes.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == ACCESS) && !PREADY
                        && (wait_cnt == CNT_LAST);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (req_i) state_nxt = misaligned ? ERR : SETUP;
         SETUP:  state_nxt = ACCESS;
         ACCESS: if (PREADY || timeout_hit) state_nxt = IDLE;
         ERR:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt_o   = (state == IDLE) && PRESETn;
      PSEL    = (state == SETUP) || (state == ACCESS);
      PENABLE = (state == ACCESS);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PADDR  <= '0;
         PWRITE <= 1'b0;
         PWDATA <= '0;
      end else if (accept) begin
         PADDR  <= addr_i;
         PWRITE <= we_i;
         PWDATA <= wdata_i;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)                  wait_cnt <= '0;
      else if (state == SETUP)       wait_cnt <= '0;
      else if (state == ACCESS && !PREADY) wait_cnt <= wait_cnt + 1'b1;
   end

   // Misaligned responses are launched at accept so they appear during the ERR cycle.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rvalid_o <= 1'b0;
         err_o    <= 1'b0;
         rdata_o  <= '0;
      end else begin
         rvalid_o <= 1'b0;
         err_o    <= 1'b0;
         rdata_o  <= '0;
         if (accept && misaligned) begin
            rvalid_o <= 1'b1;
            err_o    <= 1'b1;
         end else if (state == ACCESS && PREADY) begin
            rvalid_o <= 1'b1;
            err_o    <= PSLVERR;
            rdata_o  <= PWRITE ? '0 : PRDATA;
         end else if (timeout_hit) begin
            rvalid_o <= 1'b1;
            err_o    <= 1'b1;
         end
      end
   end

endmodule
